// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, constants and helper functions for bcd_updown_counter
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // Helpers work on a fixed wide vector; narrower values are zero-extended,
  // which is neutral for both validity and magnitude compare.
  localparam int BCD_MAX_DIGITS = 16;
  localparam int BCD_WIDE_W     = 4 * BCD_MAX_DIGITS;

  typedef logic [BCD_WIDE_W-1:0] bcd_wide_t;

  // True when every nibble is a decimal digit.
  function automatic logic bcd_is_valid(input bcd_wide_t value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (value[4*i +: 4] > BCD_MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

  // a <= b, compared digit by digit from the most significant digit down.
  function automatic logic bcd_le(input bcd_wide_t a, input bcd_wide_t b);
    logic le;
    logic decided;
    le      = 1'b1;
    decided = 1'b0;
    for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        le      = (a[4*i +: 4] < b[4*i +: 4]);
        decided = 1'b1;
      end
    end
    return le;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit of the ripple chain, combinational next value
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       up,
  input  logic       down,
  input  logic       cin,
  input  logic       bin,
  output bcd_digit_t q,
  output logic       cout,
  output logic       bout
);

  // Step the digit when its carry/borrow-in is active; wrap 9->0 / 0->9 and ripple on.
  always_comb begin
    q    = d;
    cout = 1'b0;
    bout = 1'b0;
    if (up && cin) begin
      if (d == BCD_MAX_DIGIT) begin
        q    = '0;
        cout = 1'b1;
      end else begin
        q = d + 4'd1;
      end
    end else if (down && bin) begin
      if (d == '0) begin
        q    = BCD_MAX_DIGIT;
        bout = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit BCD counter with limit, load check and pulses; BCD_DOWN_EN adds down-counting
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int                         BCD_DIGITS = 2,
  parameter logic [BCD_DIGITS-1:0][3:0] LIMIT      = {BCD_DIGITS{4'd9}},
  parameter bit                         SATURATE   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clear,
  input  logic                         load,
  input  logic [BCD_DIGITS-1:0][3:0]   load_value,
  input  logic                         inc,
`ifdef BCD_DOWN_EN
  input  logic                         dec,
`endif
  output logic [BCD_DIGITS-1:0][3:0]   bcd,
  output logic                         carry,
  output logic                         borrow,
  output logic                         at_limit,
  output logic                         at_zero,
  output logic                         load_err
);

  // BCD_DIGITS is limited to BCD_MAX_DIGITS by the width of the package helpers.
  localparam bcd_wide_t LIMIT_WIDE = BCD_WIDE_W'(LIMIT);

  logic [BCD_DIGITS-1:0][3:0] bcd_q, bcd_next, ripple;
  logic                       carry_q, carry_next;
  logic                       load_err_q, load_err_next;
  logic                       borrow_next;
  logic                       count_up, count_dn;
  logic                       load_ok;
  logic [BCD_DIGITS:0]        chain_c, chain_b;
  logic                       unused_chain_top;
  bcd_wide_t                  load_wide;

`ifdef BCD_DOWN_EN
  logic borrow_q;
  assign count_up = inc & ~dec;
  assign count_dn = dec & ~inc;
  assign borrow   = borrow_q;
`else
  assign count_up = inc;
  assign count_dn = 1'b0;
  assign borrow   = 1'b0;
`endif

  assign load_wide = BCD_WIDE_W'(load_value);
  assign load_ok   = bcd_is_valid(load_wide) && bcd_le(load_wide, LIMIT_WIDE);

  // Ripple chain: digit 0 always steps, higher digits step on carry/borrow from below.
  assign chain_c[0] = 1'b1;
  assign chain_b[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .d    (bcd_q[gi]),
        .up   (count_up),
        .down (count_dn),
        .cin  (chain_c[gi]),
        .bin  (chain_b[gi]),
        .q    (ripple[gi]),
        .cout (chain_c[gi+1]),
        .bout (chain_b[gi+1])
      );
    end
  endgenerate

  // Ripple-out of the top digit only happens at all-9s/all-0s, already covered by the limit/zero decode.
  assign unused_chain_top = chain_c[BCD_DIGITS] ^ chain_b[BCD_DIGITS];

  assign at_limit = (bcd_q == LIMIT);
  assign at_zero  = (bcd_q == '0);

  // Next state with priority clear > load > count; limit/zero handling overrides the ripple result.
  always_comb begin
    bcd_next      = bcd_q;
    carry_next    = 1'b0;
    borrow_next   = 1'b0;
    load_err_next = 1'b0;
    if (clear) begin
      bcd_next = '0;
    end else if (load) begin
      if (load_ok) bcd_next = load_value;
      else         load_err_next = 1'b1;
    end else if (count_up) begin
      if (at_limit) begin
        if (!SATURATE) begin
          bcd_next   = '0;
          carry_next = 1'b1;
        end
      end else begin
        bcd_next = ripple;
      end
    end else if (count_dn) begin
      if (at_zero) begin
        if (!SATURATE) begin
          bcd_next    = LIMIT;
          borrow_next = 1'b1;
        end
      end else begin
        bcd_next = ripple;
      end
    end
  end

  // Count register and pulse flops; en low holds the count and drops pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q      <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
`ifdef BCD_DOWN_EN
      borrow_q   <= 1'b0;
`endif
    end else if (en) begin
      bcd_q      <= bcd_next;
      carry_q    <= carry_next;
      load_err_q <= load_err_next;
`ifdef BCD_DOWN_EN
      borrow_q   <= borrow_next;
`endif
    end else begin
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
`ifdef BCD_DOWN_EN
      borrow_q   <= 1'b0;
`endif
    end
  end

  assign bcd      = bcd_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter (down tests need BCD_DOWN_EN)
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] en_v = 3'b111;
  logic [2:0] clear_v = '0;
  logic [2:0] load_v = '0;
  logic [2:0] inc_v = '0;
  logic [2:0] dec_v = '0;
  logic [7:0] lv [3];
  logic [7:0] bcd_o [3];
  logic [2:0] carry_v, borrow_v, atl_v, atz_v, err_v;

  int checks = 0;
  int errors = 0;

  // Configurations: 0 = 99 wrap, 1 = 11 saturate, 2 = 21 wrap
  int lim [3] = '{99, 11, 21};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};

  // Model state kept as plain integers
  int m_val [3];
  bit m_carry [3];
  bit m_borrow [3];
  bit m_err [3];
  bit started = 1'b0;

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 3; k++) lv[k] = 8'h00;
  end

  bcd_updown_counter #(.BCD_DIGITS(2), .LIMIT(8'h99), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .clear(clear_v[0]), .load(load_v[0]),
    .load_value(lv[0]), .inc(inc_v[0]),
`ifdef BCD_DOWN_EN
    .dec(dec_v[0]),
`endif
    .bcd(bcd_o[0]), .carry(carry_v[0]), .borrow(borrow_v[0]),
    .at_limit(atl_v[0]), .at_zero(atz_v[0]), .load_err(err_v[0]));

  bcd_updown_counter #(.BCD_DIGITS(2), .LIMIT(8'h11), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .clear(clear_v[1]), .load(load_v[1]),
    .load_value(lv[1]), .inc(inc_v[1]),
`ifdef BCD_DOWN_EN
    .dec(dec_v[1]),
`endif
    .bcd(bcd_o[1]), .carry(carry_v[1]), .borrow(borrow_v[1]),
    .at_limit(atl_v[1]), .at_zero(atz_v[1]), .load_err(err_v[1]));

  bcd_updown_counter #(.BCD_DIGITS(2), .LIMIT(8'h21), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .clear(clear_v[2]), .load(load_v[2]),
    .load_value(lv[2]), .inc(inc_v[2]),
`ifdef BCD_DOWN_EN
    .dec(dec_v[2]),
`endif
    .bcd(bcd_o[2]), .carry(carry_v[2]), .borrow(borrow_v[2]),
    .at_limit(atl_v[2]), .at_zero(atz_v[2]), .load_err(err_v[2]));

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Behavioural model: decimal integer arithmetic on the count
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int  nv;
      bit  nc, nb, ne;
      int  hi, lo;
      bit  up, dn;
      nv = m_val[k]; nc = 1'b0; nb = 1'b0; ne = 1'b0;
      hi = int'(lv[k][7:4]);
      lo = int'(lv[k][3:0]);
`ifdef BCD_DOWN_EN
      up = inc_v[k] && !dec_v[k];
      dn = dec_v[k] && !inc_v[k];
`else
      up = inc_v[k];
      dn = 1'b0;
`endif
      if (rst) begin
        nv = 0;
      end else if (en_v[k]) begin
        if (clear_v[k]) nv = 0;
        else if (load_v[k]) begin
          if (hi <= 9 && lo <= 9 && (hi * 10 + lo) <= lim[k]) nv = hi * 10 + lo;
          else ne = 1'b1;
        end else if (up) begin
          if (m_val[k] == lim[k]) begin
            if (!sat[k]) begin nv = 0; nc = 1'b1; end
          end else nv = m_val[k] + 1;
        end else if (dn) begin
          if (m_val[k] == 0) begin
            if (!sat[k]) begin nv = lim[k]; nb = 1'b1; end
          end else nv = m_val[k] - 1;
        end
      end
      m_val[k]    <= nv;
      m_carry[k]  <= nc;
      m_borrow[k] <= nb;
      m_err[k]    <= ne;
    end
    if (rst) started <= 1'b1;
  end

  // Per-cycle compare of every DUT against the model
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        check("bcd",      k, 32'(bcd_o[k]),   32'(to_bcd(m_val[k])));
        check("carry",    k, 32'(carry_v[k]), 32'(m_carry[k]));
        check("borrow",   k, 32'(borrow_v[k]), 32'(m_borrow[k]));
        check("load_err", k, 32'(err_v[k]),   32'(m_err[k]));
        check("at_limit", k, 32'(atl_v[k]),   32'(m_val[k] == lim[k]));
        check("at_zero",  k, 32'(atz_v[k]),   32'(m_val[k] == 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    en_v[k] = 1'b1; clear_v[k] = 1'b0; load_v[k] = 1'b0;
    inc_v[k] = 1'b0; dec_v[k] = 1'b0;
  endtask

  task automatic do_load(input int k, input logic [7:0] v);
    lv[k] = v; load_v[k] = 1'b1;
    tick();
    idle(k);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("pin_reset_bcd", 0, 32'(bcd_o[0]), 32'h00);
    check("pin_reset_zero", 0, 32'(atz_v[0]), 32'd1);
    check("pin_reset_limit", 1, 32'(atl_v[1]), 32'd0);

    // 100 increments on the 99-wrap counter
    inc_v[0] = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 10) check("pin_09_to_10", 0, 32'(bcd_o[0]), 32'h10);
      if (i == 99) check("pin_99", 0, 32'({bcd_o[0], carry_v[0]}), 32'({8'h99, 1'b0}));
      if (i == 100) check("pin_wrap", 0, 32'({bcd_o[0], carry_v[0], atz_v[0]}), 32'({8'h00, 1'b1, 1'b1}));
    end
    idle(0);
    tick();
    check("pin_carry_drop", 0, 32'(carry_v[0]), 32'd0);

    // 15 increments on the saturating 11 counter
    inc_v[1] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 10) check("pin_sat_10", 1, 32'({bcd_o[1], atl_v[1]}), 32'({8'h10, 1'b0}));
      if (i == 11) check("pin_sat_11", 1, 32'({bcd_o[1], atl_v[1]}), 32'({8'h11, 1'b1}));
      if (i == 15) check("pin_sat_hold", 1, 32'({bcd_o[1], carry_v[1]}), 32'({8'h11, 1'b0}));
    end
    idle(1);

`ifdef BCD_DOWN_EN
    // Down-counting with decimal borrow and wrap to LIMIT
    do_load(2, 8'h10);
    dec_v[2] = 1'b1; tick(); idle(2);
    check("pin_dec_10_09", 2, 32'(bcd_o[2]), 32'h09);
    do_load(2, 8'h00);
    dec_v[2] = 1'b1; tick(); idle(2);
    check("pin_borrow_wrap", 2, 32'({bcd_o[2], borrow_v[2]}), 32'({8'h21, 1'b1}));
    inc_v[2] = 1'b1; dec_v[2] = 1'b1; tick(); idle(2);
    check("pin_inc_dec", 2, 32'({bcd_o[2], borrow_v[2]}), 32'({8'h21, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      dec_v[2] = 1'b1; tick();
    end
    idle(2);
`endif

    // Load validation on the 21-limit counter
    do_load(2, 8'h15);
    check("pin_load_15", 2, 32'({bcd_o[2], err_v[2]}), 32'({8'h15, 1'b0}));
    do_load(2, 8'h3A);
    check("pin_load_3a", 2, 32'({bcd_o[2], err_v[2]}), 32'({8'h15, 1'b1}));
    do_load(2, 8'h25);
    check("pin_load_25", 2, 32'({bcd_o[2], err_v[2]}), 32'({8'h15, 1'b1}));
    do_load(2, 8'h21);
    check("pin_load_limit", 2, 32'({bcd_o[2], err_v[2], atl_v[2]}), 32'({8'h21, 1'b0, 1'b1}));
    do_load(2, 8'h22);
    do_load(2, 8'h9F);
    tick();

    // Priority: clear over load over count
    do_load(0, 8'h45);
    clear_v[0] = 1'b1; load_v[0] = 1'b1; inc_v[0] = 1'b1; lv[0] = 8'h30;
    tick(); idle(0);
    check("pin_clear_prio", 0, 32'(bcd_o[0]), 32'h00);
    lv[0] = 8'h12; load_v[0] = 1'b1; inc_v[0] = 1'b1;
    tick(); idle(0);
    check("pin_load_prio", 0, 32'(bcd_o[0]), 32'h12);

    // en low freezes the count
    do_load(0, 8'h57);
    en_v[0] = 1'b0; inc_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pin_en_hold", 0, 32'(bcd_o[0]), 32'h57);

    // Reset overrides everything with en low
    rst = 1'b1;
    tick();
    check("pin_rst", 0, 32'({bcd_o[0], carry_v[0], err_v[0], atz_v[0]}), 32'({8'h00, 1'b0, 1'b0, 1'b1}));
    rst = 1'b0;
    idle(0);
    inc_v[0] = 1'b1; tick(); tick(); idle(0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
